// File: rtl/vrased_pkg.sv
// -----------------------------------------------------------------------------
// vrased_pkg
// Shared definitions for the VRASED reset controller:
//   - FSM state encoding (2-bit, legacy-compatible constants)
//   - default reset-handler address
//   - violation counter width
// -----------------------------------------------------------------------------
package vrased_pkg;

    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_ASSERT    = 2'd1;
    localparam logic [1:0] ST_HOLD      = 2'd2;
    localparam logic [1:0] ST_WAIT_BOOT = 2'd3;

    localparam logic [15:0] DEFAULT_RESET_HANDLER = 16'h0000;

    localparam int unsigned VIOL_CNT_W = 8;

    // States in which the core is held in reset.
    function automatic logic is_reset_state(input logic [1:0] s);
        return (s == ST_ASSERT) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/vrased_rst_stretch.sv
// -----------------------------------------------------------------------------
// vrased_rst_stretch
// Loadable 8-bit down-counter that times the minimum reset width.
// Ports:
//   i_clk      clock
//   i_rst      asynchronous active-high reset (counter <= RST_VAL)
//   i_load     load i_load_val (takes priority over i_en)
//   i_load_val value to load
//   i_en       decrement by one; holds at zero
//   o_zero     counter equals zero
// -----------------------------------------------------------------------------
module vrased_rst_stretch #(
    parameter logic [7:0] RST_VAL = 8'd7
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    input  logic       i_en,
    output logic       o_zero
);

    logic [7:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= RST_VAL;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/vrased_reset_ctrl.sv
// -----------------------------------------------------------------------------
// vrased_reset_ctrl
// Merges VRASED monitor violation requests into one registered system reset,
// stretched to MIN_RST_CYCLES, held while any request persists, then tracks
// the reboot until the core reaches RESET_HANDLER. Records a sticky cause
// mask and, optionally, a saturating violation counter.
//
// Optional build macro: VRASED_VIOL_CNT_EN
//   defined   -> 8-bit saturating violation counter on viol_cnt
//   undefined -> no counter flops, viol_cnt tied to 8'h00
//
// Ports:
//   clk        system clock (posedge)
//   rst        asynchronous active-high reset
//   viol_req   [NUM_SRC] level reset requests, bit i = monitor i
//   pc         [16] core program counter
//   cause_clr  single-cycle pulse, clears cause (new requests still set it)
//   sys_rst    registered active-high reset to the core
//   cause      [NUM_SRC] sticky OR of requests since last clear
//   viol_cnt   [8] saturating violation event count
// -----------------------------------------------------------------------------
module vrased_reset_ctrl
    import vrased_pkg::*;
#(
    parameter int unsigned NUM_SRC        = 4,
    parameter int unsigned MIN_RST_CYCLES = 8,
    parameter logic [15:0] RESET_HANDLER  = DEFAULT_RESET_HANDLER
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SRC-1:0]    viol_req,
    input  logic [15:0]           pc,
    input  logic                  cause_clr,
    output logic                  sys_rst,
    output logic [NUM_SRC-1:0]    cause,
    output logic [VIOL_CNT_W-1:0] viol_cnt
);

    localparam logic [7:0] STRETCH_INIT = 8'(MIN_RST_CYCLES - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic               r_sys_rst;
    logic [NUM_SRC-1:0] r_cause;
    logic               w_any;
    logic               w_event;
    logic               w_zero;

    assign w_any = |viol_req;

    // The counter is loaded on every new violation event and only counts
    // while in ASSERT, so requests arriving mid-stretch never extend it.
    vrased_rst_stretch #(
        .RST_VAL (STRETCH_INIT)
    ) u_stretch (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (w_event),
        .i_load_val (STRETCH_INIT),
        .i_en       (r_state == ST_ASSERT),
        .o_zero     (w_zero)
    );

    always_comb begin
        w_next  = r_state;
        w_event = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_any) begin
                    w_next  = ST_ASSERT;
                    w_event = 1'b1;
                end
            end
            ST_ASSERT: begin
                if (w_zero) begin
                    w_next = w_any ? ST_HOLD : ST_WAIT_BOOT;
                end
            end
            ST_HOLD: begin
                if (!w_any) begin
                    w_next = ST_WAIT_BOOT;
                end
            end
            ST_WAIT_BOOT: begin
                // A violation wins over a simultaneous reset-handler fetch.
                if (w_any) begin
                    w_next  = ST_ASSERT;
                    w_event = 1'b1;
                end else if (pc == RESET_HANDLER) begin
                    w_next = ST_RUN;
                end
            end
            default: begin
                w_next = ST_ASSERT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_ASSERT;
            r_sys_rst <= 1'b1;
            r_cause   <= '0;
        end else begin
            r_state   <= w_next;
            // Registered from the next state so sys_rst tracks the state
            // register exactly, one cycle after the triggering sample.
            r_sys_rst <= is_reset_state(w_next);
            r_cause   <= (r_cause & ~{NUM_SRC{cause_clr}}) | viol_req;
        end
    end

    assign sys_rst = r_sys_rst;
    assign cause   = r_cause;

`ifdef VRASED_VIOL_CNT_EN
    logic [VIOL_CNT_W-1:0] r_viol_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_viol_cnt <= '0;
        end else if (w_event && (r_viol_cnt != '1)) begin
            r_viol_cnt <= r_viol_cnt + 1'b1;
        end
    end

    assign viol_cnt = r_viol_cnt;
`else
    assign viol_cnt = '0;
`endif

endmodule

// File: tb/tb_vrased_reset_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vrased_reset_ctrl
// Directed self-checking bench for vrased_reset_ctrl (NUM_SRC=4,
// MIN_RST_CYCLES=8, RESET_HANDLER=16'h0000). Expected viol_cnt follows
// VRASED_VIOL_CNT_EN.
// -----------------------------------------------------------------------------
module tb_vrased_reset_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  viol_req;
    logic [15:0] pc;
    logic        cause_clr;
    logic        sys_rst;
    logic [3:0]  cause;
    logic [7:0]  viol_cnt;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [3:0] exp_cause;
    int         events;
    int         n;
    int         bad_len;

    vrased_reset_ctrl #(
        .NUM_SRC        (4),
        .MIN_RST_CYCLES (8),
        .RESET_HANDLER  (16'h0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .viol_req  (viol_req),
        .pc        (pc),
        .cause_clr (cause_clr),
        .sys_rst   (sys_rst),
        .cause     (cause),
        .viol_cnt  (viol_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Counts consecutive high cycles of sys_rst starting with the current one.
    task automatic count_high(output int cnt);
        cnt = 0;
        while (sys_rst === 1'b1 && cnt < 1000) begin
            cnt++;
            tick();
        end
    endtask

    function automatic logic [7:0] exp_cnt(input int ev);
`ifdef VRASED_VIOL_CNT_EN
        return (ev > 255) ? 8'hFF : 8'(ev);
`else
        return 8'h00;
`endif
    endfunction

    initial begin
        rst       = 1'b1;
        viol_req  = 4'b0000;
        pc        = 16'h0000;
        cause_clr = 1'b0;
        exp_cause = 4'b0000;
        events    = 0;

        // Power-on
        repeat (3) tick();
        chk("por_sys_rst", 16'(sys_rst), 16'h1);
        chk("por_cause", 16'(cause), 16'h0);
        chk("por_cnt", 16'(viol_cnt), 16'h0);
        rst = 1'b0;
        count_high(n);
        chk("por_len", 16'(n), 16'd8);
        chk("por_wait_boot", 16'(sys_rst), 16'h0);
        tick();
        chk("por_run", 16'(sys_rst), 16'h0);
        chk("por_cnt_run", 16'(viol_cnt), 16'h0);

        // Single-cycle pulse in RUN
        viol_req = 4'b0001;
        #1;
        chk("pulse_latency", 16'(sys_rst), 16'h0);
        tick();
        viol_req = 4'b0000;
        events++; exp_cause |= 4'b0001;
        count_high(n);
        chk("pulse_len", 16'(n), 16'd8);
        chk("pulse_cause", 16'(cause), 16'(exp_cause));
        chk("pulse_cnt", 16'(viol_cnt), 16'(exp_cnt(events)));
        tick();

        // New request during ASSERT neither reloads nor counts
        viol_req = 4'b0001;
        tick();
        viol_req = 4'b0000;
        events++; exp_cause |= 4'b0001;
        tick();
        viol_req = 4'b0010;
        tick();
        viol_req = 4'b0000;
        exp_cause |= 4'b0010;
        count_high(n);
        chk("noreload_len", 16'(n + 2), 16'd8);
        chk("noreload_cnt", 16'(viol_cnt), 16'(exp_cnt(events)));
        chk("noreload_cause", 16'(cause), 16'(exp_cause));
        tick();

        // Long request held 20 cycles: ASSERT then HOLD
        viol_req = 4'b0100;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (sys_rst === 1'b1) n++;
        end
        viol_req = 4'b0000;
        events++; exp_cause |= 4'b0100;
        chk("long_high", 16'(n), 16'd20);
        tick();
        chk("long_release", 16'(sys_rst), 16'h0);
        chk("long_cnt", 16'(viol_cnt), 16'(exp_cnt(events)));
        chk("long_cause", 16'(cause), 16'(exp_cause));

        // Now in WAIT_BOOT with pc at the handler: violation wins
        viol_req = 4'b0010;
        tick();
        viol_req = 4'b0000;
        events++; exp_cause |= 4'b0010;
        chk("wb_viol_sys_rst", 16'(sys_rst), 16'h1);
        count_high(n);
        chk("wb_viol_len", 16'(n), 16'd8);
        chk("wb_viol_cnt", 16'(viol_cnt), 16'(exp_cnt(events)));
        chk("wb_viol_cause", 16'(cause), 16'(exp_cause));
        tick();

        // Clear coincident with a new request: set wins on that bit
        viol_req  = 4'b1000;
        cause_clr = 1'b1;
        tick();
        viol_req  = 4'b0000;
        cause_clr = 1'b0;
        events++; exp_cause = 4'b1000;
        chk("clr_set_cause", 16'(cause), 16'(exp_cause));
        count_high(n);
        chk("clr_set_len", 16'(n), 16'd8);
        chk("clr_set_cnt", 16'(viol_cnt), 16'(exp_cnt(events)));
        tick();

        // Clear alone
        cause_clr = 1'b1;
        tick();
        cause_clr = 1'b0;
        exp_cause = 4'b0000;
        chk("clr_only_cause", 16'(cause), 16'(exp_cause));
        chk("clr_only_sys_rst", 16'(sys_rst), 16'h0);

        // Asynchronous reset while running
        #2;
        rst = 1'b1;
        #1;
        chk("async_sys_rst", 16'(sys_rst), 16'h1);
        chk("async_cause", 16'(cause), 16'h0);
        chk("async_cnt", 16'(viol_cnt), 16'h0);
        events = 0;
        tick();
        rst = 1'b0;
        count_high(n);
        chk("async_len", 16'(n), 16'd8);
        tick();

        // Saturation: 300 separate events, multi-bit requests count once
        bad_len = 0;
        for (int i = 0; i < 300; i++) begin
            viol_req = (i % 2 == 0) ? 4'b0001 : 4'b0110;
            tick();
            viol_req = 4'b0000;
            events++;
            count_high(n);
            if (n != 8) bad_len++;
            if (i == 254) chk("sat_255", 16'(viol_cnt), 16'(exp_cnt(events)));
            tick();
        end
        chk("sat_len_errors", 16'(bad_len), 16'd0);
        chk("sat_final", 16'(viol_cnt), 16'(exp_cnt(events)));
        chk("sat_cause", 16'(cause), 16'b0111);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
